// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes bclk/lrclk/sdata into the clk domain, deserializes
// 24-bit left/right words and presents them as a pair with a one-cycle valid strobe.
module i2s_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bclk,
    input  logic        lrclk,
    input  logic        sdata,
    output logic [23:0] left_out,
    output logic [23:0] right_out,
    output logic        sample_valid,
    output logic        frame_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ALIGN = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                   bclk_s;
    logic                   lrclk_s;
    logic                   sdata_s;
    logic                   bclk_prev;
    logic                   bclk_rise;

    logic [1:0]             state;
    logic [4:0]             bit_cnt;
    logic [23:1]            shift_reg;
    logic                   channel;
    logic                   lrclk_prev;
    logic                   left_held;
    logic [23:0]            left_hold;
    logic [23:0]            right_hold;
    logic                   pair_go;
    logic [23:0]            word;
    logic                   lr_changed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            sdata_sync <= '0;
            bclk_prev  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
            bclk_prev  <= bclk_s;
        end
    end

    // All three lines are taken from the same stage so lrclk/sdata line up with the bclk edge.
    assign bclk_s     = bclk_sync[SYNC_STAGES-1];
    assign lrclk_s    = lrclk_sync[SYNC_STAGES-1];
    assign sdata_s    = sdata_sync[SYNC_STAGES-1];
    assign bclk_rise  = bclk_s & ~bclk_prev;
    assign lr_changed = (lrclk_s != lrclk_prev);
    assign word       = {shift_reg, sdata_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= 5'd0;
            shift_reg    <= '0;
            channel      <= 1'b0;
            lrclk_prev   <= 1'b1;
            left_held    <= 1'b0;
            left_hold    <= '0;
            right_hold   <= '0;
            pair_go      <= 1'b0;
            left_out     <= '0;
            right_out    <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            pair_go      <= 1'b0;

            if (pair_go) begin
                left_out     <= left_hold;
                right_out    <= right_hold;
                sample_valid <= 1'b1;
                left_held    <= 1'b0;
            end

            if (bclk_rise) begin
                lrclk_prev <= lrclk_s;
                case (state)
                    IDLE: begin
                        if (!lrclk_s && lrclk_prev) begin
                            state   <= ALIGN;
                            channel <= lrclk_s;
                        end
                    end
                    ALIGN: begin
                        shift_reg[23] <= sdata_s;
                        bit_cnt       <= 5'd1;
                        state         <= SHIFT;
                    end
                    SHIFT: begin
                        // The LSB edge completes the word even if lrclk flips on it (24-bit slots).
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= 5'd24;
                            if (!channel) begin
                                left_hold <= word;
                                left_held <= 1'b1;
                            end else if (left_held) begin
                                right_hold <= word;
                                pair_go    <= 1'b1;
                            end
                            if (lr_changed) begin
                                state   <= ALIGN;
                                channel <= lrclk_s;
                            end else begin
                                state <= DRAIN;
                            end
                        end else if (lr_changed) begin
                            frame_err <= 1'b1;
                            left_held <= 1'b0;
                            bit_cnt   <= 5'd0;
                            state     <= ALIGN;
                            channel   <= lrclk_s;
                        end else begin
                            shift_reg[5'd23 - bit_cnt] <= sdata_s;
                            bit_cnt                    <= bit_cnt + 5'd1;
                        end
                    end
                    DRAIN: begin
                        if (lr_changed) begin
                            state   <= ALIGN;
                            channel <= lrclk_s;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives randomized I2S streams into two receivers (2 and 3
// synchronizer stages) and compares against a slot-level behavioural model.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        bclk = 1'b0;
    logic        lrclk = 1'b1;
    logic        sdata = 1'b0;
    logic [23:0] left_out, right_out, left_out3, right_out3;
    logic        sample_valid, frame_err, sample_valid3, frame_err3;

    i2s_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .left_out(left_out), .right_out(right_out),
        .sample_valid(sample_valid), .frame_err(frame_err)
    );

    i2s_rx #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .left_out(left_out3), .right_out(right_out3),
        .sample_valid(sample_valid3), .frame_err(frame_err3)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ch;
        int          nbits;
        logic [23:0] word;
        bit          rst;
    } slot_t;

    slot_t       slots[$];
    logic        lr_arr[0:2047];
    logic        sd_arr[0:2047];
    logic        rlsb_arr[0:2047];
    int          n_per;
    int          rst_period;

    logic [47:0] obs_pairs[$], obs3_pairs[$], exp_pairs[$];
    time         obs_times[$], obs3_times[$], lsb_times[$];
    int          err_cnt, err3_cnt, exp_err;
    int          checks = 0;
    int          failures = 0;

    task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Collect what each receiver reports, timestamped with the clk edge it appeared on.
    always @(posedge clk) begin : monitor
        time t;
        t = $time;
        #1;
        if (sample_valid) begin
            obs_pairs.push_back({left_out, right_out});
            obs_times.push_back(t);
        end
        if (sample_valid3) begin
            obs3_pairs.push_back({left_out3, right_out3});
            obs3_times.push_back(t);
        end
        if (frame_err) err_cnt++;
        if (frame_err3) err3_cnt++;
        if (sample_valid || frame_err)
            checkOutput("valid_err_exclusive", 48'(sample_valid & frame_err), 48'd0);
    end

    task automatic add_slot(input bit ch, input int nbits, input logic [23:0] word, input bit rst = 1'b0);
        slot_t s;
        s.ch = ch; s.nbits = nbits; s.word = word; s.rst = rst;
        slots.push_back(s);
    endtask

    function automatic void build_stream();
        int base;
        n_per = 0;
        rst_period = -1;
        for (int i = 0; i < 2048; i++) begin
            lr_arr[i] = 1'b0; sd_arr[i] = 1'b0; rlsb_arr[i] = 1'b0;
        end
        foreach (slots[k]) begin
            base = n_per;
            for (int p = 0; p < slots[k].nbits; p++) lr_arr[base+p] = slots[k].ch;
            for (int i = 0; i < 24 && i < slots[k].nbits; i++) sd_arr[base+1+i] = slots[k].word[23-i];
            if (slots[k].ch && slots[k].nbits >= 24) rlsb_arr[base+24] = 1'b1;
            if (slots[k].rst) rst_period = base + 10;
            n_per += slots[k].nbits;
        end
        lr_arr[n_per] = 1'b0;
        lr_arr[n_per+1] = 1'b0;
        n_per += 2;
    endfunction

    // Slot-level reference: pairs are emitted for a full left followed by a full right,
    // a short slot is an error that forgets the held left word, and nothing counts until
    // a left slot has been seen after reset.
    function automatic void model();
        bit          synced = 1'b0;
        bit          held = 1'b0;
        logic [23:0] hl = '0;
        exp_pairs.delete();
        exp_err = 0;
        foreach (slots[k]) begin
            if (slots[k].rst) begin
                synced = 1'b0;
                held = 1'b0;
                continue;
            end
            if (!synced) begin
                if (slots[k].ch) continue;
                synced = 1'b1;
            end
            if (slots[k].nbits < 24) begin
                exp_err++;
                held = 1'b0;
            end else if (!slots[k].ch) begin
                hl = slots[k].word;
                held = 1'b1;
            end else if (held) begin
                exp_pairs.push_back({hl, slots[k].word});
                held = 1'b0;
            end
        end
    endfunction

    task automatic new_scenario();
        bclk = 1'b0; lrclk = 1'b1; sdata = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        obs_pairs.delete(); obs3_pairs.delete();
        obs_times.delete(); obs3_times.delete(); lsb_times.delete();
        err_cnt = 0; err3_cnt = 0;
        slots.delete();
    endtask

    // bclk at 16x below clk, edges placed mid clk cycle; data changes on bclk falling.
    task automatic applyStimulus();
        build_stream();
        for (int p = 0; p < n_per; p++) begin
            bclk = 1'b0; lrclk = lr_arr[p]; sdata = sd_arr[p];
            repeat (8) @(negedge clk);
            bclk = 1'b1;
            if (rlsb_arr[p]) lsb_times.push_back($time);
            if (p == rst_period) begin
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                #1;
                checkOutput("rst_mid_outputs", {left_out, right_out}, 48'd0);
                checkOutput("rst_mid_strobes", 48'({sample_valid, frame_err}), 48'd0);
                checkOutput("rst_mid_outputs3", {left_out3, right_out3}, 48'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
        end
        bclk = 1'b0;
        repeat (32) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        model();
        checkOutput($sformatf("%s_pair_count", tag), 48'(obs_pairs.size()), 48'(exp_pairs.size()));
        checkOutput($sformatf("%s_pair_count3", tag), 48'(obs3_pairs.size()), 48'(exp_pairs.size()));
        foreach (exp_pairs[i]) begin
            checkOutput($sformatf("%s_pair%0d", tag, i),
                        (i < obs_pairs.size()) ? obs_pairs[i] : 48'd0, exp_pairs[i]);
            checkOutput($sformatf("%s_pair%0d_s3", tag, i),
                        (i < obs3_pairs.size()) ? obs3_pairs[i] : 48'd0, exp_pairs[i]);
        end
        checkOutput($sformatf("%s_frame_err", tag), 48'(err_cnt), 48'(exp_err));
        checkOutput($sformatf("%s_frame_err3", tag), 48'(err3_cnt), 48'(exp_err));
        if (exp_pairs.size() > 0)
            checkOutput($sformatf("%s_hold", tag), {left_out, right_out}, exp_pairs[exp_pairs.size()-1]);
    endtask

    function automatic longint latency(input time lsb_t, input time valid_t);
        return (longint'(valid_t) - longint'(lsb_t) + 5) / 10;
    endfunction

    initial begin
        longint lat;
        logic [23:0] w;
        int cut;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {left_out, right_out}, 48'd0);
        checkOutput("reset_strobes", 48'({sample_valid, frame_err}), 48'd0);
        checkOutput("reset_outputs3", {left_out3, right_out3}, 48'd0);

        $display("[TB] scenario 1: 32-bit slots, full-scale pair, latency");
        new_scenario();
        add_slot(1'b0, 32, 24'h7FFFFF);
        add_slot(1'b1, 32, 24'h800000);
        applyStimulus();
        verify("s1");
        checkOutput("s1_left_value", 48'(left_out), 48'h7FFFFF);
        checkOutput("s1_right_value", 48'(right_out), 48'h800000);
        lat = (lsb_times.size() > 0 && obs_times.size() > 0) ? latency(lsb_times[0], obs_times[0]) : -1;
        checkOutput("s1_latency_sync2", 48'(lat), 48'd4);
        lat = (lsb_times.size() > 0 && obs3_times.size() > 0) ? latency(lsb_times[0], obs3_times[0]) : -1;
        checkOutput("s1_latency_sync3", 48'(lat), 48'd5);

        $display("[TB] scenario 2: eight 24-bit frames L=n R=-n");
        new_scenario();
        for (int n = 1; n <= 8; n++) begin
            add_slot(1'b0, 24, 24'(n));
            add_slot(1'b1, 24, 24'(-n));
        end
        applyStimulus();
        verify("s2");
        for (int i = 1; i < 8; i++)
            checkOutput($sformatf("s2_spacing%0d", i),
                        (i < obs_times.size()) ? 48'(obs_times[i] - obs_times[i-1]) : 48'd0,
                        48'd7680);

        $display("[TB] scenario 3: short left slot");
        new_scenario();
        add_slot(1'b0, 24, 24'($urandom)); add_slot(1'b1, 24, 24'($urandom));
        add_slot(1'b0, 20, 24'($urandom)); add_slot(1'b1, 24, 24'($urandom));
        add_slot(1'b0, 24, 24'($urandom)); add_slot(1'b1, 24, 24'($urandom));
        applyStimulus();
        verify("s3");

        $display("[TB] scenario 4: stream starts mid right slot");
        new_scenario();
        add_slot(1'b1, 12, 24'($urandom));
        for (int f = 0; f < 2; f++) begin
            add_slot(1'b0, 32, 24'($urandom)); add_slot(1'b1, 32, 24'($urandom));
        end
        applyStimulus();
        verify("s4");

        $display("[TB] scenario 5: reset during a right slot");
        new_scenario();
        add_slot(1'b0, 24, 24'($urandom) | 24'h1); add_slot(1'b1, 24, 24'($urandom));
        add_slot(1'b0, 24, 24'($urandom)); add_slot(1'b1, 24, 24'($urandom), 1'b1);
        add_slot(1'b0, 24, 24'($urandom)); add_slot(1'b1, 24, 24'($urandom));
        applyStimulus();
        verify("s5");

        $display("[TB] scenario 7: random widths with one short slot");
        new_scenario();
        cut = int'($urandom_range(1, 4));
        for (int f = 0; f < 6; f++) begin
            w = 24'($urandom);
            add_slot(1'b0, (f == cut) ? int'($urandom_range(4, 22)) : ($urandom_range(0, 1) ? 32 : 24), w);
            add_slot(1'b1, $urandom_range(0, 1) ? 32 : 24, 24'($urandom));
        end
        applyStimulus();
        verify("s7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
